// File: rtl/random_event_timer.sv
// random_event_timer: requests a random delay from the random_number generator, clamps it
// to the registered [rng_min, rng_max] window and pulses fire after that many ticks.
// One tick is TICK_CYCLES clock cycles.
module random_event_timer #(
   parameter int unsigned TICK_CYCLES = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        cancel,
   input  logic [31:0] min_delay,
   input  logic [31:0] max_delay,
   input  logic [31:0] rng_value,
   output logic        rng_enable,
   output logic [31:0] rng_min,
   output logic [31:0] rng_max,
   output logic        busy,
   output logic        fire,
   output logic [31:0] delay_loaded,
   output logic [31:0] remaining
);

   localparam int unsigned PsWidth = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PsWidth-1:0] PsLast = PsWidth'(TICK_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StReq, StCapture, StCount, StFire} state_e;

   state_e             state_q, state_d;
   logic [PsWidth-1:0] prescale_q;
   logic [31:0]        rng_min_q, rng_max_q, delay_q, remaining_q;
   logic [31:0]        clamped;
   logic               tick;

   // Clamp the generator output into the registered window; the window is never inverted.
   always_comb begin
      clamped = rng_value;
      if (rng_value < rng_min_q) begin
         clamped = rng_min_q;
      end else if (rng_value > rng_max_q) begin
         clamped = rng_max_q;
      end
      tick = (prescale_q == PsLast);
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; cancel wins over every transition out of REQ, CAPTURE and COUNT.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (start) state_d = StReq;
         StReq:     state_d = cancel ? StIdle : StCapture;
         StCapture: begin
            if (cancel)             state_d = StIdle;
            else if (clamped == '0) state_d = StFire;
            else                    state_d = StCount;
         end
         StCount: begin
            if (cancel)                            state_d = StIdle;
            else if (tick && remaining_q == 32'd1) state_d = StFire;
         end
         StFire:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Outputs decoded straight from the state register or from datapath registers.
   always_comb begin
      rng_enable   = (state_q == StReq);
      busy         = (state_q != StIdle);
      fire         = (state_q == StFire);
      rng_min      = rng_min_q;
      rng_max      = rng_max_q;
      delay_loaded = delay_q;
      remaining    = remaining_q;
   end

   // Datapath: range capture on start, delay load on capture, prescaled countdown.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rng_min_q   <= '0;
         rng_max_q   <= '0;
         delay_q     <= '0;
         remaining_q <= '0;
         prescale_q  <= '0;
      end else begin
         if (state_q == StIdle && start) begin
            rng_min_q <= min_delay;
            rng_max_q <= (min_delay > max_delay) ? min_delay : max_delay;
         end
         case (state_q)
            StReq: begin
               if (cancel) begin
                  remaining_q <= '0;
                  prescale_q  <= '0;
               end
            end
            StCapture: begin
               prescale_q <= '0;
               if (cancel) begin
                  remaining_q <= '0;
               end else begin
                  delay_q     <= clamped;
                  remaining_q <= clamped;
               end
            end
            StCount: begin
               if (cancel) begin
                  remaining_q <= '0;
                  prescale_q  <= '0;
               end else if (tick) begin
                  prescale_q <= '0;
                  if (remaining_q != '0) begin
                     remaining_q <= remaining_q - 32'd1;
                  end
               end else begin
                  prescale_q <= prescale_q + PsWidth'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_random_event_timer.sv
// Bench for random_event_timer: directed scenarios plus randomized draws. Expected
// rng_enable and fire events are queued when start is issued; a negedge monitor pops them.
module tb_random_event_timer;

   localparam int unsigned Tick = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        cancel = 1'b0;
   logic [31:0] min_delay = '0;
   logic [31:0] max_delay = '0;
   logic [31:0] rng_value = '0;
   logic        rng_enable, busy, fire;
   logic [31:0] rng_min, rng_max, delay_loaded, remaining;

   random_event_timer #(.TICK_CYCLES(Tick)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .cancel       (cancel),
      .min_delay    (min_delay),
      .max_delay    (max_delay),
      .rng_value    (rng_value),
      .rng_enable   (rng_enable),
      .rng_min      (rng_min),
      .rng_max      (rng_max),
      .busy         (busy),
      .fire         (fire),
      .delay_loaded (delay_loaded),
      .remaining    (remaining)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic [31:0] a;
      logic [31:0] b;
   } ev_t;

   ev_t req_q[$];
   ev_t fire_q[$];
   int  cyc = 0;
   int  busy_start = -1;
   int  busy_end = -1;
   int  total = 0;
   int  bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, act, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rng_enable"}, 32'(rng_enable), 0);
      check({tag, "_rng_min"}, rng_min, 0);
      check({tag, "_rng_max"}, rng_max, 0);
      check({tag, "_busy"}, 32'(busy), 0);
      check({tag, "_fire"}, 32'(fire), 0);
      check({tag, "_delay_loaded"}, delay_loaded, 0);
      check({tag, "_remaining"}, remaining, 0);
   endtask

   // Monitor: busy window every cycle, and each rng_enable / fire pulse against the queues.
   always @(negedge clk) begin
      ev_t e;
      check("busy", 32'(busy), 32'(cyc >= busy_start && cyc <= busy_end));
      if (rng_enable) begin
         if (req_q.size() == 0) begin
            check("unexpected_rng_enable", 32'(rng_enable), 0);
         end else begin
            e = req_q.pop_front();
            check("req_cycle", cyc, e.cyc);
            check("rng_min", rng_min, e.a);
            check("rng_max", rng_max, e.b);
         end
      end
      if (fire) begin
         if (fire_q.size() == 0) begin
            check("unexpected_fire", 32'(fire), 0);
         end else begin
            e = fire_q.pop_front();
            check("fire_cycle", cyc, e.cyc);
            check("fire_delay_loaded", delay_loaded, e.a);
            check("fire_remaining", remaining, 0);
         end
      end
   end

   // Called 1ns after a posedge; start is driven in that cycle (cycle 0). Returns 1ns after
   // the posedge that begins the first idle cycle. abort_at > 0 cancels (or resets) in that
   // cycle; extra_at > 0 raises a start that must be ignored.
   task automatic run_one(input logic [31:0] mn, input logic [31:0] mx, input logic [31:0] v,
                          input int abort_at, input bit abort_reset, input int extra_at);
      logic [31:0] hi, d;
      int t0, fc;
      hi = (mn > mx) ? mn : mx;
      d  = (v < mn) ? mn : ((v > hi) ? hi : v);
      t0 = cyc;
      fc = t0 + 3 + int'(d) * Tick;
      min_delay = mn;
      max_delay = mx;
      rng_value = v;
      start     = 1'b1;
      req_q.push_back('{t0 + 1, mn, hi});
      fire_q.push_back('{fc, d, 0});
      busy_start = t0 + 1;
      busy_end   = fc;
      for (int k = 1; k <= fc - t0 + 1; k++) begin
         @(posedge clk);
         #1;
         start  = 1'b0;
         cancel = 1'b0;
         if (k == 3) begin
            check("loaded_at_3", delay_loaded, d);
            check("remaining_at_3", remaining, d);
         end
         if (k == extra_at) start = 1'b1;
         if (k == abort_at) begin
            void'(fire_q.pop_back());
            if (abort_reset) begin
               busy_end = -1;
               reset = 1'b1;
               #1;
               check_all_zero("reset_now");
               start = 1'b0;
               @(posedge clk);
               #2;
               reset = 1'b0;
               check_all_zero("reset_release");
            end else begin
               busy_end = t0 + k;
               cancel = 1'b1;
               @(posedge clk);
               #1;
               cancel = 1'b0;
               start  = 1'b0;
               check("cancel_busy", 32'(busy), 0);
               check("cancel_remaining", remaining, 0);
            end
            return;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // 1. Reset, released mid-cycle, then a quiet stretch.
      #2;
      check_all_zero("reset_hold");
      @(posedge clk);
      #3;
      reset = 1'b0;
      check_all_zero("reset_rel");
      idle(20);

      // 2. Nominal draw: fire in cycle 15.
      run_one(2, 5, 3, 0, 0, 0);
      idle(2);

      // 3. Zero delay, ignored start during FIRE, back-to-back start in the idle cycle.
      run_one(0, 7, 0, 0, 0, 3);
      run_one(0, 7, 1, 0, 0, 0);
      idle(2);

      // 4. Inverted range clamps high, then low clamp.
      run_one(9, 4, 20, 0, 0, 0);
      run_one(2, 5, 1, 0, 0, 0);
      idle(1);

      // 5. Cancel in COUNT with an ignored start earlier; no fire afterwards.
      run_one(5, 5, 5, 8, 0, 6);
      idle(35);

      // 6. Reset mid-COUNT, then a normal sequence.
      run_one(5, 5, 5, 10, 1, 0);
      run_one(1, 3, 2, 0, 0, 0);
      idle(2);

      // Randomized draws, some cancelled, some with ignored starts.
      for (int i = 0; i < 40; i++) begin
         logic [31:0] mn, mx, v;
         int span, ab, ex;
         mn = $urandom_range(0, 6);
         mx = $urandom_range(0, 6);
         v  = $urandom_range(0, 10);
         span = 3 + int'(((v < mn) ? mn : ((v > ((mn > mx) ? mn : mx)) ?
                          ((mn > mx) ? mn : mx) : v))) * Tick;
         ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, span - 1) : 0;
         ex = ($urandom_range(0, 2) == 0) ? $urandom_range(1, span) : 0;
         run_one(mn, mx, v, ab, 0, ex);
         idle($urandom_range(0, 3));
      end

      idle(5);
      check("req_queue_drained", req_q.size(), 0);
      check("fire_queue_drained", fire_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
